// File: rtl/debug_loader_unit.sv
// debug_loader_unit
// Pulls bytes from the UART RX FIFO and packs them MSB-first into instruction
// words, then writes those words to consecutive instruction-memory addresses
// until the halt word has been written. After loading, it gates the pipeline
// clock enable in either run mode or single-step mode and counts the enabled
// cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// LOAD_WAIT  | idle in load phase, waiting for a byte at the FIFO head
// LOAD_POP   | pop one byte and shift it into the word register
// LOAD_WRITE | write the assembled word to instruction memory
// READY      | program loaded, waiting for start_i
// RUN        | pipeline enabled continuously until pipe_halted_i
// STEP_WAIT  | pipeline stalled, waiting for step_i
// STEP_EXEC  | pipeline enabled for exactly one cycle
// HALTED     | execution finished, exits only on reset
// ERROR      | memory filled without the halt word, exits only on reset
module debug_loader_unit #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned NB_ADDR = 10,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_BYTE-1:0] rx_data,
    input  logic               rx_empty,
    output logic               rx_read,
    input  logic               start_i,
    input  logic               step_mode_i,
    input  logic               step_i,
    input  logic               pipe_halted_i,
    output logic               imem_wr_en_o,
    output logic [NB_ADDR-1:0] imem_wr_addr_o,
    output logic [NB_DATA-1:0] imem_wr_data_o,
    output logic               word_done_o,
    output logic               load_done_o,
    output logic               pipe_enable_o,
    output logic               halted_o,
    output logic               overflow_o,
    output logic [31:0]        cycle_count_o
);

    localparam int unsigned BYTES  = NB_DATA / NB_BYTE;
    localparam int unsigned NB_CNT = $clog2(BYTES + 1);

    typedef enum logic [3:0] {
        S_LOAD_WAIT  = 4'd0,
        S_LOAD_POP   = 4'd1,
        S_LOAD_WRITE = 4'd2,
        S_READY      = 4'd3,
        S_RUN        = 4'd4,
        S_STEP_WAIT  = 4'd5,
        S_STEP_EXEC  = 4'd6,
        S_HALTED     = 4'd7,
        S_ERROR      = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic [31:0]        cycle_q, cycle_d;
    logic               pipe_en;

    // Pipeline enable depends only on the registered state.
    assign pipe_en = (state_q == S_RUN) || (state_q == S_STEP_EXEC);

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        cycle_d = cycle_q;

        if (pipe_en && (cycle_q != 32'hFFFF_FFFF)) begin
            cycle_d = cycle_q + 32'd1;
        end

        case (state_q)
            S_LOAD_WAIT: begin
                if (!rx_empty) begin
                    state_d = S_LOAD_POP;
                end
            end
            S_LOAD_POP: begin
                shreg_d = {shreg_q[NB_DATA-NB_BYTE-1:0], rx_data};
                cnt_d   = cnt_q + NB_CNT'(1);
                // Going back through LOAD_WAIT gives the FIFO a cycle to
                // update rx_empty after the pop.
                if (cnt_q == NB_CNT'(BYTES - 1)) begin
                    state_d = S_LOAD_WRITE;
                end else begin
                    state_d = S_LOAD_WAIT;
                end
            end
            S_LOAD_WRITE: begin
                cnt_d  = '0;
                addr_d = addr_q + NB_ADDR'(1);
                if (shreg_q == HALT_WORD) begin
                    state_d = S_READY;
                end else if (addr_q == '1) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_LOAD_WAIT;
                end
            end
            S_READY: begin
                if (start_i) begin
                    state_d = step_mode_i ? S_STEP_WAIT : S_RUN;
                end
            end
            S_RUN: begin
                if (pipe_halted_i) begin
                    state_d = S_HALTED;
                end
            end
            S_STEP_WAIT: begin
                // A halt report wins over a step request in the same cycle.
                if (pipe_halted_i) begin
                    state_d = S_HALTED;
                end else if (step_i) begin
                    state_d = S_STEP_EXEC;
                end
            end
            S_STEP_EXEC: begin
                // step_i is not queued here; only one enabled cycle per request.
                state_d = S_STEP_WAIT;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_LOAD_WAIT;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_LOAD_WAIT;
            cnt_q   <= '0;
            addr_q  <= '0;
            shreg_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            cycle_q <= cycle_d;
        end
    end

    // Every output is a decode of registered state or a registered datapath value.
    assign rx_read        = (state_q == S_LOAD_POP);
    assign imem_wr_en_o   = (state_q == S_LOAD_WRITE);
    assign word_done_o    = (state_q == S_LOAD_WRITE);
    assign imem_wr_addr_o = (state_q == S_LOAD_WRITE) ? addr_q : '0;
    assign imem_wr_data_o = (state_q == S_LOAD_WRITE) ? shreg_q : '0;
    assign load_done_o    = (state_q == S_READY) || (state_q == S_RUN) ||
                            (state_q == S_STEP_WAIT) || (state_q == S_STEP_EXEC) ||
                            (state_q == S_HALTED);
    assign pipe_enable_o  = pipe_en;
    assign halted_o       = (state_q == S_HALTED);
    assign overflow_o     = (state_q == S_ERROR);
    assign cycle_count_o  = cycle_q;

endmodule
